vga_v_timing_gen: RTL and testbench

//  Downstream of the horizontal counter: consumes hcount/end_of_line on pclk, keeps the vertical

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_v_timing_gen_if.sv | 25 ++
 rtl/vga_v_counter.sv | 28 ++
 rtl/vga_v_timing_gen.sv | 102 ++++++++++
 tb/tb_vga_v_timing_gen.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants and vertical phase type
// Default timing is 800x600@60 with a 40 MHz pixel clock.
package vga_pkg;

   localparam int H_Tot_time = 1056;

   localparam int H_ACT  = 800;
   localparam int H_FP   = 40;
   localparam int H_SYNC = 128;
   localparam int H_TOT  = H_Tot_time;

   localparam int V_ACT  = 600;
   localparam int V_FP   = 1;
   localparam int V_SYNC = 4;
   localparam int V_TOT  = 628;

   typedef enum logic [1:0] {V_ACTIVE, V_FP_S, V_SYNC_S, V_BP} v_state_t;

   // Vertical phase that owns a given line index.
   function automatic v_state_t v_phase(input logic [10:0] line, input int v_act,
                                        input int v_fp, input int v_sync);
      if (int'(line) < v_act)
         return V_ACTIVE;
      else if (int'(line) < v_act + v_fp)
         return V_FP_S;
      else if (int'(line) < v_act + v_fp + v_sync)
         return V_SYNC_S;
      else
         return V_BP;
   endfunction

endpackage

// File: rtl/vga_v_timing_gen_if.sv
// rtl/vga_v_timing_gen_if.sv - horizontal-in / timing-out bundle of the vertical timing generator
interface vga_v_timing_gen_if;

   logic [10:0] hcount_in;
   logic        end_of_line;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic        frame_start;
   logic [15:0] frame_cnt;

   modport master (
      output hcount_in, end_of_line,
      input  hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt
   );

   modport slave (
      input  hcount_in, end_of_line,
      output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt
   );

endinterface

// File: rtl/vga_v_counter.sv
// rtl/vga_v_counter.sv - vertical line counter, advanced and wrapped by end_of_line
// vl_next is exported so the phase FSM can move together with the counter.
module vga_v_counter #(
   parameter int V_TOT = vga_pkg::V_TOT
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        end_of_line,
   output logic [10:0] vl,
   output logic [10:0] vl_next
);

   localparam logic [10:0] VL_LAST = 11'(V_TOT - 1);

   always_comb begin
      vl_next = vl;
      if (end_of_line)
         vl_next = (vl == VL_LAST) ? 11'd0 : vl + 11'd1;
   end

   always_ff @(posedge pclk) begin
      if (rst)
         vl <= '0;
      else
         vl <= vl_next;
   end

endmodule

// File: rtl/vga_v_timing_gen.sv
// rtl/vga_v_timing_gen.sv - vertical phase FSM and registered sync/blank outputs
// Optional VGA_FRAME_CNT_EN adds the 16-bit frame counter; otherwise frame_cnt is tied to 0.
module vga_v_timing_gen #(
   parameter int H_ACT  = vga_pkg::H_ACT,
   parameter int H_FP   = vga_pkg::H_FP,
   parameter int H_SYNC = vga_pkg::H_SYNC,
   parameter int H_TOT  = vga_pkg::H_TOT,
   parameter int V_ACT  = vga_pkg::V_ACT,
   parameter int V_FP   = vga_pkg::V_FP,
   parameter int V_SYNC = vga_pkg::V_SYNC,
   parameter int V_TOT  = vga_pkg::V_TOT
) (
   input logic               pclk,
   input logic               rst,
   vga_v_timing_gen_if.slave bus
);

   import vga_pkg::*;

   localparam logic [10:0] HB_START = 11'(H_ACT);
   localparam logic [10:0] HS_START = 11'(H_ACT + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACT + H_FP + H_SYNC);
   localparam logic [10:0] H_LIM    = 11'(H_TOT);

   logic [10:0] vl;
   logic [10:0] vl_next;
   v_state_t    state;
   v_state_t    state_next;
   logic        in_range;
   logic        hblnk_c;
   logic        hsync_c;
   logic        vblnk_c;
   logic        vsync_c;
   logic        frame_start_c;

   vga_v_counter #(.V_TOT(V_TOT)) u_v_counter (
      .pclk        (pclk),
      .rst         (rst),
      .end_of_line (bus.end_of_line),
      .vl          (vl),
      .vl_next     (vl_next)
   );

   always_ff @(posedge pclk) begin
      if (rst)
         state <= V_ACTIVE;
      else
         state <= state_next;
   end

   // Deriving the phase from the next line both sequences normally and resyncs after a skip.
   always_comb begin
      state_next = state;
      if (bus.end_of_line)
         state_next = v_phase(vl_next, V_ACT, V_FP, V_SYNC);
   end

   always_comb begin
      in_range      = bus.hcount_in < H_LIM;
      hblnk_c       = !in_range || (bus.hcount_in >= HB_START);
      hsync_c       = in_range && (bus.hcount_in >= HS_START) && (bus.hcount_in < HS_END);
      vblnk_c       = (state != V_ACTIVE);
      vsync_c       = (state == V_SYNC_S);
      frame_start_c = (bus.hcount_in == 11'd0) && (vl == 11'd0);
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         bus.hcount      <= '0;
         bus.vcount      <= '0;
         bus.hsync       <= 1'b0;
         bus.vsync       <= 1'b0;
         bus.hblnk       <= 1'b0;
         bus.vblnk       <= 1'b0;
         bus.frame_start <= 1'b0;
      end else begin
         bus.hcount      <= bus.hcount_in;
         bus.vcount      <= vl;
         bus.hsync       <= hsync_c;
         bus.vsync       <= vsync_c;
         bus.hblnk       <= hblnk_c;
         bus.vblnk       <= vblnk_c;
         bus.frame_start <= frame_start_c;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge pclk) begin
      if (rst)
         frame_cnt_q <= '0;
      else if (frame_start_c)
         frame_cnt_q <= frame_cnt_q + 16'd1;
   end

   assign bus.frame_cnt = frame_cnt_q;
`else
   assign bus.frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_v_timing_gen.sv
// tb/tb_vga_v_timing_gen.sv - scoreboard bench for vga_v_timing_gen with a line-level reference model
module tb_vga_v_timing_gen;

   localparam int HA = 800, HFP = 40, HS = 128, HT = 1056;
   localparam int VA = 600, VFP = 1, VS = 4, VT = 628;

   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic        fs;
      logic [15:0] fc;
   } obs_t;

   logic pclk = 1'b0;
   logic rst  = 1'b1;

   vga_v_timing_gen_if vif();

   vga_v_timing_gen dut (
      .pclk (pclk),
      .rst  (rst),
      .bus  (vif)
   );

   always #5 pclk = ~pclk;

   obs_t exp_q[$];
   int   due_q[$];
   int   cyc    = 0;
   int   tests  = 0;
   int   fails  = 0;
   bit   done   = 1'b0;
   int   m_line = 0;
   int   m_fcnt = 0;
   int   bnd[9] = '{0, 799, 800, 839, 840, 967, 968, 1500, 2047};

   always @(posedge pclk) cyc <= cyc + 1;

   // Reference model: expected outputs follow directly from the line number and pixel index.
   task automatic drive(input int h, input bit eol, input bit r);
      obs_t e;
      vif.hcount_in   = 11'(h);
      vif.end_of_line = eol;
      rst             = r;
      if (r) begin
         e      = '0;
         m_line = 0;
         m_fcnt = 0;
      end else begin
         e.h  = 11'(h);
         e.v  = 11'(m_line);
         e.hb = (h >= HA);
         e.hs = (h >= HA + HFP) && (h < HA + HFP + HS);
         e.vb = (m_line >= VA);
         e.vs = (m_line >= VA + VFP) && (m_line < VA + VFP + VS);
         e.fs = (h == 0) && (m_line == 0);
         if (e.fs)
            m_fcnt = (m_fcnt + 1) % 65536;
`ifdef VGA_FRAME_CNT_EN
         e.fc = 16'(m_fcnt);
`else
         e.fc = 16'h0000;
`endif
         if (eol)
            m_line = (m_line + 1) % VT;
      end
      exp_q.push_back(e);
      due_q.push_back(cyc + 1);
      @(posedge pclk);
      #1;
   endtask

   task automatic run_line(input bit full, input bit glitchy);
      if (full) begin
         for (int h = 0; h < HT; h++)
            drive(h, h == HT - 1, 1'b0);
      end else begin
         if (glitchy && (m_line == VA - 1 || m_line == VA + VFP + VS - 1))
            drive(200, 1'b1, 1'b0);
         for (int i = 0; i < 9; i++) begin
            if (glitchy && $urandom_range(0, 15) == 0)
               drive(200, 1'b1, 1'b0);
            drive(bnd[i], 1'b0, 1'b0);
         end
         drive(int'($urandom_range(1, HT - 2)), 1'b0, 1'b0);
         drive(HT - 1, 1'b1, 1'b0);
      end
   endtask

   task automatic run_frame(input bit glitchy, input bit with_full);
      int guard = 0;
      do begin
         run_line(with_full && !glitchy && m_line == 10, glitchy);
         guard++;
      end while (m_line != 0 && guard < 2 * VT);
   endtask

   initial begin
      vif.hcount_in   = '0;
      vif.end_of_line = 1'b0;
      drive(0, 1'b0, 1'b1);
      drive(0, 1'b0, 1'b1);
      for (int f = 0; f < 3; f++)
         run_frame(1'b0, f == 0);
      run_frame(1'b1, 1'b0);
      for (int n = 0; n < VT && m_line != 300; n++)
         run_line(1'b0, 1'b0);
      for (int h = 0; h < 500; h += 50)
         drive(h, 1'b0, 1'b0);
      drive(500, 1'b0, 1'b1);
      run_frame(1'b0, 1'b0);
      done = 1'b1;
   end

   initial begin
      obs_t a;
      obs_t e;
      int   d;
      forever begin
         @(negedge pclk);
         if (due_q.size() > 0 && due_q[0] <= cyc) begin
            e = exp_q.pop_front();
            d = due_q.pop_front();
            a = {vif.hcount, vif.vcount, vif.hsync, vif.vsync, vif.hblnk, vif.vblnk,
                 vif.frame_start, vif.frame_cnt};
            tests++;
            if (a !== e) begin
               fails++;
               $display("FAIL outputs cyc=%0d got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b fc=%0d required h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b fc=%0d",
                        d, a.h, a.v, a.hs, a.vs, a.hb, a.vb, a.fs, a.fc,
                        e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.fs, e.fc);
            end
         end
         if (done) begin
            tests++;
            if (exp_q.size() != 0) begin
               fails++;
               $display("FAIL drain got %0d pending required 0", exp_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL timeout got done=%b required done=1", done);
      $fatal(1, "timeout");
   end

endmodule
